// File: rtl/eth_pkg.sv
// Shared Ethernet rx/tx definitions.
//   AXI_DATA_WIDTH        : byte-wide AXI-stream data path
//   DEFAULT_MAX_FRAME_LEN : default forwarding limit per frame (bytes)
//   arb_state_t           : packet arbiter FSM states
package eth_pkg;
  localparam int AXI_DATA_WIDTH        = 8;
  localparam int DEFAULT_MAX_FRAME_LEN = 1518;

  typedef enum logic [1:0] {ARB_IDLE, ARB_FWD, ARB_DRAIN} arb_state_t;
endpackage

// File: rtl/eth_rx_pkt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     : request vector, one bit per requester
//   rr_ptr  : highest-priority index for this pick
//   grant   : first requesting index at or above rr_ptr, wrapping
//   any_req : at least one request present (grant is meaningless otherwise)
module rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      grant,
  output logic               any_req
);
  int idx;

  // Walk the ring from farthest to nearest so the request closest to
  // rr_ptr is the last one written and therefore wins.
  always_comb begin
    grant   = rr_ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        grant   = IW'(idx);
        any_req = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_rx_pkt_arbiter.sv
// eth_rx_pkt_arbiter: frame-granular round-robin scheduler that shares one
// byte-wide AXI-stream consumer between NUM_PORTS MAC rx FIFOs.
//   clk_100, reset       : clock, synchronous active-high reset
//   s_rx_axis_*          : per-port rx streams (port i byte at [8i+7:8i])
//   m_rx_axis_*          : merged stream towards the IP/UDP parser
//   grant_id             : port currently owning the output
//   trunc_pulse          : one cycle per frame cut at MAX_FRAME_LEN
// A grant lasts a whole frame. Frames longer than MAX_FRAME_LEN are cut,
// closed with tlast+tuser, and the rest of the frame is drained upstream.
module eth_rx_pkt_arbiter
  import eth_pkg::*;
#(
  parameter  int NUM_PORTS     = 2,
  parameter  int MAX_FRAME_LEN = DEFAULT_MAX_FRAME_LEN,
  parameter  int CNT_WIDTH     = 11,
  localparam int GW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                clk_100,
  input  logic                                reset,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_rx_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_rx_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_rx_axis_tlast,
  input  logic [NUM_PORTS-1:0]                s_rx_axis_tuser,
  output logic [NUM_PORTS-1:0]                s_rx_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0]           m_rx_axis_tdata,
  output logic                                m_rx_axis_tvalid,
  output logic                                m_rx_axis_tlast,
  output logic                                m_rx_axis_tuser,
  input  logic                                m_rx_axis_trdy,
  output logic [GW-1:0]                       grant_id,
  output logic                                trunc_pulse
);
  arb_state_t           state, state_nxt;
  logic [GW-1:0]        rr_ptr, rr_ptr_nxt, grant_nxt, pick, rr_after;
  logic [CNT_WIDTH-1:0] byte_cnt, cnt_nxt;
  logic                 any_req, at_limit;
  logic [AXI_DATA_WIDTH-1:0] g_tdata;
  logic                 g_tvalid, g_tlast, g_tuser;

  rr_pick #(.NUM_REQ(NUM_PORTS)) u_pick (
    .req     (s_rx_axis_tvalid),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign g_tdata  = s_rx_axis_tdata[grant_id*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign g_tvalid = s_rx_axis_tvalid[grant_id];
  assign g_tlast  = s_rx_axis_tlast[grant_id];
  assign g_tuser  = s_rx_axis_tuser[grant_id];
  // Byte at this count is the last one we may forward.
  assign at_limit = (byte_cnt == CNT_WIDTH'(MAX_FRAME_LEN - 1));
  assign rr_after = (grant_id == GW'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_nxt        = state;
    rr_ptr_nxt       = rr_ptr;
    grant_nxt        = grant_id;
    cnt_nxt          = byte_cnt;
    s_rx_axis_trdy   = '0;
    m_rx_axis_tdata  = '0;
    m_rx_axis_tvalid = 1'b0;
    m_rx_axis_tlast  = 1'b0;
    m_rx_axis_tuser  = 1'b0;
    trunc_pulse      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          grant_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = ARB_FWD;
        end
      end
      ARB_FWD: begin
        // m_tvalid depends only on the upstream valid, never on m_trdy.
        m_rx_axis_tdata  = g_tdata;
        m_rx_axis_tvalid = g_tvalid;
        m_rx_axis_tlast  = g_tlast | at_limit;
        // Input tuser only counts on a genuine last beat; a cut is always bad.
        m_rx_axis_tuser  = (g_tlast & g_tuser) | (at_limit & ~g_tlast);
        s_rx_axis_trdy[grant_id] = m_rx_axis_trdy;
        if (g_tvalid && m_rx_axis_trdy) begin
          cnt_nxt = byte_cnt + 1'b1;
          if (g_tlast) begin
            state_nxt  = ARB_IDLE;
            rr_ptr_nxt = rr_after;
          end else if (at_limit) begin
            trunc_pulse = 1'b1;
            state_nxt   = ARB_DRAIN;
          end
        end
      end
      ARB_DRAIN: begin
        // Swallow the tail of an oversize frame without waiting on downstream.
        s_rx_axis_trdy[grant_id] = 1'b1;
        if (g_tvalid && g_tlast) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = rr_after;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    // Keep the handshake quiet while reset is held so no beat is consumed.
    if (reset) begin
      s_rx_axis_trdy   = '0;
      m_rx_axis_tdata  = '0;
      m_rx_axis_tvalid = 1'b0;
      m_rx_axis_tlast  = 1'b0;
      m_rx_axis_tuser  = 1'b0;
      trunc_pulse      = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
      byte_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_eth_rx_pkt_arbiter.sv
module tb_eth_rx_pkt_arbiter;
  localparam int NP = 3, MFL = 16, CW = 5, GW = $clog2(NP);

  logic clk_100 = 1'b0;
  logic reset   = 1'b1;
  logic [NP*8-1:0] s_tdata  = '0;
  logic [NP-1:0]   s_tvalid = '0, s_tlast = '0, s_tuser = '0, s_trdy;
  logic [7:0]      m_tdata;
  logic            m_tvalid, m_tlast, m_tuser, trunc_pulse;
  logic            m_trdy = 1'b0;
  logic [GW-1:0]   grant_id;

  always #5 clk_100 = ~clk_100;

  eth_rx_pkt_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_LEN(MFL), .CNT_WIDTH(CW)) dut (
    .clk_100(clk_100), .reset(reset),
    .s_rx_axis_tdata(s_tdata), .s_rx_axis_tvalid(s_tvalid), .s_rx_axis_tlast(s_tlast),
    .s_rx_axis_tuser(s_tuser), .s_rx_axis_trdy(s_trdy),
    .m_rx_axis_tdata(m_tdata), .m_rx_axis_tvalid(m_tvalid), .m_rx_axis_tlast(m_tlast),
    .m_rx_axis_tuser(m_tuser), .m_rx_axis_trdy(m_trdy),
    .grant_id(grant_id), .trunc_pulse(trunc_pulse)
  );

  typedef struct {logic [7:0] d; logic last; logic user;} beat_t;
  typedef struct {logic [7:0] d; logic last; logic user; logic trunc; int port; bit gap2;} exp_t;

  beat_t  src_q[NP][$];
  exp_t   exp_q[$];
  bit     mid[NP];
  bit     xf[NP];
  bit     src_en = 0, tight = 0;
  int     model_ptr = 0;
  int     n_vec = 0, n_err = 0;
  longint cyc = 0, last_cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream FIFOs: each port presents its queued bytes; mid-frame gaps are
  // random unless in tight mode, a frame's first byte is never delayed.
  initial forever begin
    @(negedge clk_100);
    for (int p = 0; p < NP; p++) xf[p] = s_tvalid[p] & s_trdy[p];
    @(posedge clk_100); #1;
    for (int p = 0; p < NP; p++) begin
      beat_t b;
      if (xf[p] && src_q[p].size() > 0) begin
        b = src_q[p].pop_front();
        mid[p] = !b.last;
      end
      if (src_en && src_q[p].size() > 0 &&
          (s_tvalid[p] || !mid[p] || tight || $urandom_range(0, 99) >= 30)) begin
        b = src_q[p][0];
        s_tvalid[p] = 1'b1;
        s_tdata[p*8 +: 8] = b.d;
        s_tlast[p] = b.last;
        s_tuser[p] = b.user;
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        s_tuser[p]  = 1'b0;
        s_tdata[p*8 +: 8] = 8'h00;
      end
    end
    m_trdy = tight ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Monitor: checks every presented output beat against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk_100);
    cyc++;
    if (m_tvalid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_beat: got data %0h with no expected beat (cycle %0d)", m_tdata, cyc);
      end else begin
        e = exp_q[0];
        chk("s_trdy", 32'(s_trdy), m_trdy ? (32'd1 << e.port) : 32'd0);
        chk("grant_id", 32'(grant_id), 32'(e.port));
        if (m_trdy) begin
          void'(exp_q.pop_front());
          chk("tdata", 32'(m_tdata), 32'(e.d));
          chk("tlast", 32'(m_tlast), 32'(e.last));
          chk("tuser", 32'(m_tuser), 32'(e.user));
          chk("trunc_pulse", 32'(trunc_pulse), 32'(e.trunc));
          if (e.gap2) chk("arb_gap", 32'(cyc - last_cyc), 32'd2);
          last_cyc = cyc;
        end
      end
    end
    if (!(m_tvalid && m_trdy)) chk("trunc_idle", 32'(trunc_pulse), 32'd0);
  end

  task automatic add_frame(int p, int len, bit bad);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d    = 8'($urandom);
      b.last = (i == len - 1);
      b.user = b.last ? bad : 1'($urandom_range(0, 1));
      src_q[p].push_back(b);
    end
  endtask

  // Reference: serve whole frames round-robin from model_ptr among ports that
  // still hold frames; forward at most MFL bytes, cutting with last+user.
  task automatic plan();
    beat_t q[NP][$];
    beat_t b;
    exp_t  e;
    int    p, c, i;
    bit    first, prev_tr, tr;
    first = 1; prev_tr = 0;
    for (int k = 0; k < NP; k++) q[k] = src_q[k];
    while (1) begin
      p = -1;
      for (int k = 0; k < NP; k++) begin
        c = (model_ptr + k) % NP;
        if (p < 0 && q[c].size() > 0) p = c;
      end
      if (p < 0) break;
      i = 0; tr = 0;
      while (1) begin
        b = q[p].pop_front();
        if (i < MFL) begin
          e.d = b.d; e.port = p;
          e.gap2 = tight && (i == 0) && !first && !prev_tr;
          if (i == MFL - 1 && !b.last) begin
            e.last = 1; e.user = 1; e.trunc = 1; tr = 1;
          end else begin
            e.last = b.last; e.user = b.last & b.user; e.trunc = 0;
          end
          exp_q.push_back(e);
        end
        i++;
        if (b.last) break;
      end
      prev_tr = tr; first = 0;
      model_ptr = (p + 1) % NP;
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 0;
    return exp_q.size() == 0;
  endfunction

  task automatic run_phase(bit t);
    int k;
    tight = t;
    plan();
    src_en = 1;
    k = 0;
    while (!all_empty() && k < 3000) begin @(posedge clk_100); k++; end
    chk("phase_done", 32'(k < 3000), 32'd1);
    if (k >= 3000) begin
      for (int p = 0; p < NP; p++) src_q[p].delete();
      exp_q.delete();
    end
    src_en = 0;
    repeat (3) @(posedge clk_100);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
    chk({tag, "_m_tlast"},  32'(m_tlast), 0);
    chk({tag, "_m_tuser"},  32'(m_tuser), 0);
    chk({tag, "_s_trdy"},   32'(s_trdy), 0);
    chk({tag, "_grant_id"}, 32'(grant_id), 0);
    chk({tag, "_trunc"},    32'(trunc_pulse), 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    chk_quiet("reset");
    @(posedge clk_100); #2 reset = 0;
    repeat (2) @(posedge clk_100);

    // Single frame, then two-port and three-port contention, all back-to-back.
    add_frame(0, 12, 0);                          run_phase(1);
    add_frame(0, 10, 0); add_frame(1, 10, 0);     run_phase(1);
    add_frame(0, 10, 0); add_frame(1, 10, 0);     run_phase(1);
    for (int p = 0; p < NP; p++) begin add_frame(p, 5 + p, p == 2); add_frame(p, 3, 0); end
    run_phase(1);
    // Bad frame flag on the last byte, and single-byte frames.
    add_frame(1, 8, 1); add_frame(2, 1, 1); add_frame(0, 1, 0); run_phase(1);
    // Length boundaries around the forwarding limit.
    add_frame(0, 20, 0); add_frame(0, 16, 0); add_frame(1, 17, 1);
    add_frame(2, 15, 1); add_frame(2, 16, 1);     run_phase(1);
    // Backpressure and source gaps.
    add_frame(2, 16, 0); add_frame(0, 30, 0);     run_phase(0);
    for (int r = 0; r < 12; r++) begin
      for (int p = 0; p < NP; p++)
        for (int f = $urandom_range(0, 3); f > 0; f--)
          add_frame(p, $urandom_range(1, 24), 1'($urandom_range(0, 1)));
      run_phase(0);
    end

    // Reset mid-frame on port 1, then confirm arbitration restarts at port 0.
    add_frame(1, 40, 0);
    tight = 1; plan(); src_en = 1;
    k = 0;
    while (exp_q.size() > 8 && k < 1000) begin @(posedge clk_100); k++; end
    chk("reset_setup", 32'(k < 1000), 32'd1);
    @(posedge clk_100); #2 reset = 1; src_en = 0;
    @(posedge clk_100); #2 reset = 0;
    for (int p = 0; p < NP; p++) begin src_q[p].delete(); mid[p] = 0; end
    exp_q.delete();
    model_ptr = 0;
    @(negedge clk_100);
    chk_quiet("midreset");
    for (int p = NP - 1; p >= 0; p--) add_frame(p, 4, 0);
    run_phase(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors %0d errors", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/eth_rx_pkt_arbiter.md
Name: eth_rx_pkt_arbiter

Overview:
Packet-granular round-robin scheduler that shares one downstream 8-bit AXI-stream consumer between NUM_PORTS MAC rx FIFOs. It sits after the per-port rx FIFOs and ahead of the IP/UDP parser. A grant is held for a whole frame. Frames longer than MAX_FRAME_LEN are truncated, flagged and drained.

Parameters:
NUM_PORTS, 2, number of rx FIFO requesters (2..8)
MAX_FRAME_LEN, 1518, max bytes forwarded per frame before truncation (>=2)
CNT_WIDTH, 11, byte counter width; must satisfy 2**CNT_WIDTH > MAX_FRAME_LEN

Ports:
clk_100  in  1  system clock
reset  in  1  synchronous, active-high reset
s_rx_axis_tdata  in  NUM_PORTS*8  per-port byte; port i at [8i+7:8i]
s_rx_axis_tvalid  in  NUM_PORTS  per-port valid
s_rx_axis_tlast  in  NUM_PORTS  per-port last byte of frame
s_rx_axis_tuser  in  NUM_PORTS  per-port bad-frame flag, valid with tlast
s_rx_axis_trdy  out  NUM_PORTS  per-port ready
m_rx_axis_tdata  out  8  forwarded byte
m_rx_axis_tvalid  out  1  forwarded valid
m_rx_axis_tlast  out  1  forwarded last
m_rx_axis_tuser  out  1  bad/truncated frame flag, valid with tlast
m_rx_axis_trdy  in  1  downstream ready
grant_id  out  $clog2(NUM_PORTS)  currently granted port
trunc_pulse  out  1  one-cycle pulse on each truncation

Behaviour:
- Beat transfer = valid & trdy on the same rising edge of clk_100.
- Reset (synchronous, any state, including mid-frame):
  - state=IDLE, rr_ptr=0, grant_id=0, byte_cnt=0.
  - All s_rx_axis_trdy=0, m_rx_axis_tvalid/tlast/tuser=0, trunc_pulse=0.
  - Any partial frame left upstream is not repaired.
- FSM states: IDLE, FWD, DRAIN.
- IDLE:
  - All trdy=0, m_tvalid=0.
  - If any s_tvalid is set, pick the first asserted port searching from rr_ptr upward with wrap. Register it in grant_id, clear byte_cnt, go to FWD.
  - Arbitration costs exactly 1 idle cycle between frames.
- FWD (combinational pass-through, zero latency):
  - m_tdata/m_tvalid/m_tlast/m_tuser = granted port's signals.
  - s_trdy[grant_id] = m_trdy; all other trdy=0.
  - byte_cnt increments on each transfer.
  - Transfer with s_tlast=1 -> IDLE, rr_ptr = grant_id+1 (mod NUM_PORTS).
  - Transfer with byte_cnt==MAX_FRAME_LEN-1 and s_tlast=0 (truncation):
    - Force m_tlast=1 and m_tuser=1 on that beat.
    - trunc_pulse=1 for that cycle.
    - Go to DRAIN.
  - A frame of exactly MAX_FRAME_LEN bytes ending in tlast is not truncated.
- DRAIN:
  - m_tvalid=0; s_trdy[grant_id]=1 regardless of m_trdy.
  - Input bytes are discarded.
  - Transfer with s_tlast=1 -> IDLE, rr_ptr advances.
- Input s_tuser is passed through only when m_tlast comes from the input. Truncation always sets m_tuser=1.
- Non-granted ports are never dropped; they only stall.
- Downstream backpressure (m_trdy=0) holds the granted port's trdy low. No bytes are lost.
- Wrap-around: rr_ptr at NUM_PORTS-1 advances to 0.
- No combinational path from m_trdy to m_tvalid.

Decomposition:
- eth_pkg (shared): AXI_DATA_WIDTH=8; typedef enum logic [1:0] {ARB_IDLE, ARB_FWD, ARB_DRAIN} arb_state_t; default MAX_FRAME_LEN constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any_req.
  - Reusable by the tx scheduler.

Test Plan:
1. Port0 sends 64-byte frame, m_trdy=1 -> 64 contiguous output beats, tlast on byte 64, tuser=0, grant_id=0; port1 trdy stays 0.
2. Both ports hold 10-byte frames at once, rr_ptr=0 -> output order: port0 frame, 1 idle cycle, port1 frame. Next simultaneous request serves port0 again.
3. Port1 frame with tuser=1 on last byte -> m_tuser=1 on m_tlast beat; the next arbitration starts from port0.
4. MAX_FRAME_LEN=16, port0 sends 20 bytes:
   - 16 bytes forwarded, byte 16 has tlast=1 and tuser=1, trunc_pulse high 1 cycle.
   - 4 bytes drained with m_tvalid=0; then IDLE.
   - A 16-byte frame under the same setting passes untruncated.
5. Random m_trdy toggling (50%) during a 100-byte frame -> output byte sequence identical to input; s_trdy[g] equals m_trdy every cycle.
6. Reset asserted at byte 30 of a frame -> next cycle all outputs 0, state IDLE, rr_ptr=0; after reset, the next request is granted normally.
